mem_xbar: RTL

Parametrised data-side interconnect between the core's memory port and N_TGT memory-mapped targets (RAM, ROM data port, peripherals), replacing the shared, multiply-driven read bus at the top level. Decodes each request against a per-target base/mask map and drives exactly one target's request strobe. Tracks a single outstanding read and returns registered read data with an explicit valid strobe. Signals bus errors for unmapped accesses and for writes to read-only targets.

---
 rtl/core_config_pkg.sv | 4 +
 rtl/mem_xbar_pkg.sv | 12 +
 rtl/mem_xbar_decode.sv | 32 +++
 rtl/mem_xbar.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the data-side blocks.
package core_config_pkg;
   localparam int XLEN = 32;
endpackage

// File: rtl/mem_xbar_pkg.sv
// Shared types for the data-side crossbar.
package mem_xbar_pkg;
   localparam int MAX_TGT = 16;
   localparam int TGT_IW  = $clog2(MAX_TGT);

   typedef logic [TGT_IW-1:0] tgt_idx_t;

   typedef enum logic {
      IDLE,
      WAIT
   } xbar_state_t;
endpackage

// File: rtl/mem_xbar_decode.sv
// Address map decode: selects the lowest-indexed target whose masked
// base matches, and reports whether that target is read-only.
module mem_xbar_decode
   import mem_xbar_pkg::*;
#(
   parameter int                           XLEN     = 32,
   parameter int                           N_TGT    = 4,
   parameter logic [N_TGT-1:0][XLEN-1:0] TGT_BASE = '0,
   parameter logic [N_TGT-1:0][XLEN-1:0] TGT_MASK = '0,
   parameter logic [N_TGT-1:0]            TGT_RO   = '0
) (
   input  logic [XLEN-1:0] addr,
   output tgt_idx_t        sel,
   output logic            hit,
   output logic            ro
);

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      sel = '0;
      hit = 1'b0;
      ro  = 1'b0;
      for (int i = N_TGT - 1; i >= 0; i--) begin
         if ((addr & TGT_MASK[i]) == TGT_BASE[i]) begin
            sel = tgt_idx_t'(i);
            hit = 1'b1;
            ro  = TGT_RO[i];
         end
      end
   end

endmodule

// File: rtl/mem_xbar.sv
// Core data port to N_TGT memory-mapped targets, one outstanding read.
// Optional read timeout: define MEM_XBAR_TIMEOUT_EN.
module mem_xbar
   import mem_xbar_pkg::*;
#(
   parameter int                           XLEN     = core_config_pkg::XLEN,
   parameter int                           N_TGT    = 4,
   parameter logic [N_TGT-1:0][XLEN-1:0] TGT_BASE = '0,
   parameter logic [N_TGT-1:0][XLEN-1:0] TGT_MASK = '0,
   parameter logic [N_TGT-1:0]            TGT_RO   = '0,
   parameter int                           TIMEOUT  = 16
) (
   input  logic                           clk,
   input  logic                           aclr,
   input  logic                           m_req,
   input  logic                           m_we,
   input  logic [XLEN-1:0]                m_addr,
   input  logic [XLEN/8-1:0]              m_byteen,
   input  logic [XLEN-1:0]                m_wdata,
   output logic                           m_ready,
   output logic                           m_rvalid,
   output logic [XLEN-1:0]                m_rdata,
   output logic                           m_err,
   output logic [N_TGT-1:0]               t_req,
   output logic                           t_we,
   output logic [XLEN-1:0]                t_addr,
   output logic [XLEN/8-1:0]              t_byteen,
   output logic [XLEN-1:0]                t_wdata,
   input  logic [N_TGT-1:0][XLEN-1:0]    t_rdata,
   input  logic [N_TGT-1:0]               t_rvalid
);

   xbar_state_t     state_q, state_d;
   tgt_idx_t        sel_q;
   tgt_idx_t        dec_sel;
   logic            dec_hit, dec_ro;
   logic            accept, fault, load_sel;
   logic            sel_rvalid;
   logic [XLEN-1:0] sel_rdata;
   logic            rvalid_d, err_d;
   logic [XLEN-1:0] rdata_d;

   mem_xbar_decode #(
      .XLEN     (XLEN),
      .N_TGT    (N_TGT),
      .TGT_BASE (TGT_BASE),
      .TGT_MASK (TGT_MASK),
      .TGT_RO   (TGT_RO)
   ) u_decode (
      .addr (m_addr),
      .sel  (dec_sel),
      .hit  (dec_hit),
      .ro   (dec_ro)
   );

   assign m_ready  = (state_q == IDLE) && !aclr;
   assign accept   = m_req && m_ready;
   assign fault    = !dec_hit || (m_we && dec_ro);
   assign t_we     = m_we;
   assign t_addr   = m_addr;
   assign t_byteen = m_byteen;
   assign t_wdata  = m_wdata;

   always_comb begin
      t_req = '0;
      for (int i = 0; i < N_TGT; i++) begin
         if (accept && !fault && dec_sel == tgt_idx_t'(i)) begin
            t_req[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < N_TGT; i++) begin
         if (sel_q == tgt_idx_t'(i)) begin
            sel_rvalid = t_rvalid[i];
            sel_rdata  = t_rdata[i];
         end
      end
   end

`ifdef MEM_XBAR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             expired;

   assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Held at zero outside WAIT, so it starts from zero on every entry.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         cnt_q <= '0;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = m_rdata;
      load_sel = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && fault) begin
               err_d = 1'b1;
               if (!m_we) begin
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
               end
            end else if (accept && !m_we) begin
               load_sel = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (sel_rvalid) begin
               rvalid_d = 1'b1;
               rdata_d  = sel_rdata;
               state_d  = IDLE;
`ifdef MEM_XBAR_TIMEOUT_EN
            end else if (expired) begin
               rvalid_d = 1'b1;
               err_d    = 1'b1;
               rdata_d  = '0;
               state_d  = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         m_rvalid <= 1'b0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
      end else begin
         state_q  <= state_d;
         m_rvalid <= rvalid_d;
         m_err    <= err_d;
         m_rdata  <= rdata_d;
         if (load_sel) begin
            sel_q <= dec_sel;
         end
      end
   end

endmodule
